simd_batch_fetch: RTL
=====================

Name: simd_batch_fetch

Overview:
- Upstream feeder for the bilinear SIMD datapath (N-lane interpolation top with start/done batch handshake).
- Walks the destination frame in raster order and maps each destination pixel to a Q8.8 source coordinate.
- Reads the four source neighbours of each pixel from a synchronous 1-cycle-latency source memory.
- Packs N pixels into held vectors (I00/I10/I01/I11/alpha/beta), pulses batch_start, then waits for batch_done before building the next batch.

Parameters:
- N, 4, lanes per batch (must match the SIMD top).
- SRC_W, 64, source width in pixels (≤256).
- SRC_H, 64, source height in pixels (≤256).
- DST_W, 128, destination width.
- DST_H, 128, destination height.
- AW, 16, source memory address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse; starts a frame (sampled only in IDLE).
- step_x  in  16  Q8.8 source step per destination column; sampled at frame_start.
- step_y  in  16  Q8.8 source step per destination row; sampled at frame_start.
- mem_rd_en  out  1  source read strobe.
- mem_addr  out  AW  source address, computed as y*SRC_W+x.
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- batch_start  out  1  1-cycle pulse; vectors are valid.
- batch_done  in  1  done pulse from the SIMD top.
- I00_vec, I10_vec, I01_vec, I11_vec  out  8 x N  neighbours (x0,y0), (x0+1,y0), (x0,y0+1), (x0+1,y0+1).
- alpha_vec, beta_vec  out  8 x N  x and y fractions.
- lane_valid  out  N  lane holds a real pixel.
- batch_base  out  32  destination index of lane 0.
- busy  out  1  frame in progress.
- frame_done  out  1  1-cycle pulse after the last batch_done.

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - All outputs are 0, including mem_rd_en, batch_start, frame_done, busy, all vectors, lane_valid and batch_base.
  - All counters and accumulators clear.
- Coordinates:
  - x_acc starts at 0 each row and adds step_x per destination column.
  - y_acc adds step_y per row.
  - Accumulators are 24-bit and do not wrap within legal frames.
  - x0 = min(x_acc[23:8], SRC_W-1) and x1 = min(x0+1, SRC_W-1); y0 and y1 use the same rule with SRC_H.
  - alpha = x_acc[7:0] and beta = y_acc[7:0], unmodified even when clamped.
- FSM states: IDLE, FETCH, DRAIN, START, WAIT, FIN.
- IDLE: on frame_start, latch steps, set busy=1, go to FETCH.
- FETCH: lasts 4N cycles.
  - Issue one read per cycle, read k = 0..4N-1.
  - Lane = k/4; neighbour order is I00, I10, I01, I11.
  - The pixel coordinate advances after each lane's 4th read.
- Capture: mem_rdata from read k is registered into its lane/neighbour slot the cycle after issue.
- DRAIN: 1 cycle; captures the last read; mem_rd_en=0.
- START: batch_start=1 for exactly 1 cycle, then go to WAIT.
- Latency: batch_start fires 4N+2 cycles after the frame_start sample (or after the batch_done sample of the previous batch).
- WAIT:
  - Vectors, lane_valid and batch_base are held stable.
  - On batch_done: go to FIN if the last pixel has been packed, otherwise go to FETCH.
  - batch_base += N on each new batch.
- FIN: frame_done=1 for 1 cycle, busy=0, go to IDLE.
- Partial final batch (DST_W*DST_H mod N ≠ 0):
  - Padded lanes still consume read slots, with mem_addr=0.
  - Their captured data, alpha and beta are forced to 0.
  - lane_valid bit is 0 for padded lanes.
- Ignored events:
  - batch_done outside WAIT is ignored.
  - frame_start outside IDLE is ignored.
  - A batch_done coincident with entry into WAIT is not possible (START precedes it) and needs no handling.
- Reset mid-FETCH/WAIT: abort immediately; no batch_start and no frame_done are emitted.

Test Plan:
- Bench setup for all scenarios: N=4, SRC_W=SRC_H=4, DST_W=DST_H=8, mem[a]=a, step_x=step_y=0x0080, memory model with 1-cycle latency.
- Frame start, first batch:
  - batch_start exactly 18 cycles after the frame_start sample.
  - I00=[0,0,1,1], I10=[1,1,2,2], I01=[4,4,5,5], I11=[5,5,6,6].
  - alpha=[00,80,00,80], beta=0, lane_valid=1111, batch_base=0.
- Right/bottom clamp:
  - batch_base=60 (dst row 7, cols 4..7) gives lane 3 I00=15, I10=15, I01=15, I11=15, alpha=80, beta=80.
  - batch_base=4 lane 3 gives I00=3, I10=3, I01=7, I11=7.
- Hold/back-pressure: delay batch_done 50 cycles in WAIT → vectors unchanged, mem_rd_en=0 throughout; extra batch_done pulses in FETCH are ignored.
- Partial batch, DST_W=DST_H=3:
  - 3 batch_start pulses.
  - Final batch: lane_valid=0001, lanes 1-3 all zero, batch_base=8.
  - frame_done 1 cycle after the 3rd batch_done sample.
- Reset mid-frame: assert rst low during the 2nd FETCH → all outputs 0 asynchronously; a subsequent frame_start replays batch 0 identically.
- Full frame: 16 batches, batch_base 0..60 step 4, exactly one frame_done, busy high from the cycle after frame_start through FIN.

Source files
------------

// File: rtl/simd_batch_fetch.sv
// rtl/simd_batch_fetch.sv - raster-order batch fetcher feeding the N-lane bilinear SIMD datapath
//
// Walks the destination frame in raster order, maps each pixel to a Q8.8
// source coordinate, reads its four source neighbours and packs N pixels
// into held vectors, then hands the batch over with a start/done handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   frame_start          starts a frame when idle; step_x/step_y latched here
//   step_x, step_y       Q8.8 source step per destination column / row
//   mem_rd_en, mem_addr  source read request, address y*SRC_W+x
//   mem_rdata            source data, valid one cycle after mem_rd_en
//   batch_start          one-cycle pulse, vectors valid
//   batch_done           SIMD top finished the current batch
//   I00/I10/I01/I11_vec  neighbour bytes per lane, lane i at [8*i +: 8]
//   alpha_vec, beta_vec  x / y fractions per lane
//   lane_valid           lane holds a real pixel
//   batch_base           destination index of lane 0
//   busy, frame_done     frame in progress, end-of-frame pulse
module simd_batch_fetch #(
   parameter int N     = 4,
   parameter int SRC_W = 64,
   parameter int SRC_H = 64,
   parameter int DST_W = 128,
   parameter int DST_H = 128,
   parameter int AW    = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           frame_start,
   input  logic [15:0]    step_x,
   input  logic [15:0]    step_y,
   output logic           mem_rd_en,
   output logic [AW-1:0]  mem_addr,
   input  logic [7:0]     mem_rdata,
   output logic           batch_start,
   input  logic           batch_done,
   output logic [8*N-1:0] I00_vec,
   output logic [8*N-1:0] I10_vec,
   output logic [8*N-1:0] I01_vec,
   output logic [8*N-1:0] I11_vec,
   output logic [8*N-1:0] alpha_vec,
   output logic [8*N-1:0] beta_vec,
   output logic [N-1:0]   lane_valid,
   output logic [31:0]    batch_base,
   output logic           busy,
   output logic           frame_done
);
   localparam int              KW      = $clog2(4*N+1);
   localparam logic [KW-1:0]   RK_END  = KW'(4*N);
   localparam logic [31:0]     TOTAL   = 32'(DST_W*DST_H);
   localparam logic [31:0]     XMAX    = 32'(SRC_W-1);
   localparam logic [31:0]     YMAX    = 32'(SRC_H-1);
   localparam logic [31:0]     DX_LAST = 32'(DST_W-1);

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, START, WAIT, FIN} state_t;
   state_t state;

   logic [15:0]   sx_q, sy_q;
   logic [23:0]   x_acc, y_acc;
   logic [31:0]   dx, pix;
   logic [KW-1:0] rk, iss_k, cap_k;
   logic          iss_pad, cap_en, cap_pad;
   logic          pad, issue;
   logic [31:0]   x0, x1, y0, y1, xs, ys;
   logic [AW-1:0] rd_addr;
   logic [KW-3:0] lane, cap_lane;
   logic [7:0]    cap_data;

   // pix counts packed pixels; once it reaches TOTAL every further lane is padding.
   assign pad      = (pix >= TOTAL);
   assign lane     = rk[KW-1:2];
   assign cap_lane = cap_k[KW-1:2];
   assign cap_data = cap_pad ? 8'd0 : mem_rdata;

   // A read goes out on the edge that enters FETCH and on every FETCH edge
   // until all 4N slots are issued, so FETCH spans exactly 4N cycles.
   assign issue = (state == IDLE  && frame_start)
               || (state == WAIT  && batch_done && !pad)
               || (state == FETCH && rk != RK_END);

   always_comb begin
      x0 = 32'(x_acc[23:8]);
      if (x0 > XMAX) x0 = XMAX;
      x1 = (x0 >= XMAX) ? XMAX : x0 + 32'd1;
      y0 = 32'(y_acc[23:8]);
      if (y0 > YMAX) y0 = YMAX;
      y1 = (y0 >= YMAX) ? YMAX : y0 + 32'd1;
      xs = x0;
      ys = y0;
      case (rk[1:0])
         2'd0: begin xs = x0; ys = y0; end
         2'd1: begin xs = x1; ys = y0; end
         2'd2: begin xs = x0; ys = y1; end
         default: begin xs = x1; ys = y1; end
      endcase
      rd_addr = pad ? '0 : AW'(ys * 32'(SRC_W) + xs);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sx_q        <= '0;
         sy_q        <= '0;
         x_acc       <= '0;
         y_acc       <= '0;
         dx          <= '0;
         pix         <= '0;
         rk          <= '0;
         iss_k       <= '0;
         iss_pad     <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_addr    <= '0;
         batch_start <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         alpha_vec   <= '0;
         beta_vec    <= '0;
         lane_valid  <= '0;
         batch_base  <= '0;
      end else begin
         batch_start <= 1'b0;
         frame_done  <= 1'b0;
         mem_rd_en   <= issue;
         mem_addr    <= issue ? rd_addr : '0;

         if (issue) begin
            iss_k   <= rk;
            iss_pad <= pad;
            rk      <= rk + KW'(1);
            // The lane's fourth read is the last use of this coordinate:
            // record its fractions, then step to the next destination pixel.
            if (rk[1:0] == 2'd3) begin
               alpha_vec[8*lane +: 8] <= pad ? 8'd0 : x_acc[7:0];
               beta_vec[8*lane +: 8]  <= pad ? 8'd0 : y_acc[7:0];
               lane_valid[lane]       <= !pad;
               if (!pad) begin
                  pix <= pix + 32'd1;
                  if (dx == DX_LAST) begin
                     dx    <= '0;
                     x_acc <= '0;
                     y_acc <= y_acc + {8'd0, sy_q};
                  end else begin
                     dx    <= dx + 32'd1;
                     x_acc <= x_acc + {8'd0, sx_q};
                  end
               end
            end
         end

         case (state)
            IDLE: begin
               if (frame_start) begin
                  sx_q       <= step_x;
                  sy_q       <= step_y;
                  busy       <= 1'b1;
                  batch_base <= '0;
                  state      <= FETCH;
               end
            end
            FETCH: begin
               if (rk == RK_END) begin
                  rk    <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: state <= START;
            START: begin
               batch_start <= 1'b1;
               state       <= WAIT;
            end
            WAIT: begin
               if (batch_done) begin
                  if (pad) begin
                     frame_done <= 1'b1;
                     state      <= FIN;
                  end else begin
                     batch_base <= batch_base + 32'(N);
                     state      <= FETCH;
                  end
               end
            end
            FIN: begin
               busy  <= 1'b0;
               x_acc <= '0;
               y_acc <= '0;
               dx    <= '0;
               pix   <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data lands one cycle after the request; it is written into the
   // slot remembered from the issuing cycle, zeroed for padded lanes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_en  <= 1'b0;
         cap_k   <= '0;
         cap_pad <= 1'b0;
         I00_vec <= '0;
         I10_vec <= '0;
         I01_vec <= '0;
         I11_vec <= '0;
      end else begin
         cap_en  <= mem_rd_en;
         cap_k   <= iss_k;
         cap_pad <= iss_pad;
         if (cap_en) begin
            case (cap_k[1:0])
               2'd0: I00_vec[8*cap_lane +: 8] <= cap_data;
               2'd1: I10_vec[8*cap_lane +: 8] <= cap_data;
               2'd2: I01_vec[8*cap_lane +: 8] <= cap_data;
               default: I11_vec[8*cap_lane +: 8] <= cap_data;
            endcase
         end
      end
   end

endmodule
